led_pattern_gen: RTL



---
 rtl/led_pattern_gen_pkg.sv | 29 ++
 rtl/led_pattern_gen_tick_divider.sv | 38 +++
 rtl/led_pattern_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_pkg.sv
// Shared pattern-mode encoding, direction constants and per-mode start values
// for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Start value of the LED bank when a mode is entered; only bit 0 can be set.
  function automatic logic [31:0] init_pattern(mode_t m);
    logic [31:0] v;
    v = 32'd0;
    case (m)
      MODE_ROTATE: v = 32'd1;
      MODE_BOUNCE: v = 32'd1;
      MODE_COUNT:  v = 32'd0;
      MODE_FILL:   v = 32'd0;
      default:     v = 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// Prescaler: counts enabled clk cycles and flags the terminal count as tick.
// tick is combinational from the counter, so the step lands on the same edge the counter wraps.
module tick_divider #(
  parameter int PRESCALE = 3000000,
  parameter int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] pre_cnt_d;

  assign tick = enable && (pre_cnt_q == TERM);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (enable) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer (rotate / bounce / count / fill) stepped by a prescaler.
// Optional PWM dimming of the LED bank via `define LED_PATTERN_GEN_PWM_EN (adds duty input).
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PRESCALE = 3000000,
  parameter int PRE_W    = $clog2(PRESCALE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic                dir,
`ifdef LED_PATTERN_GEN_PWM_EN
  input  logic [7:0]          duty,
`endif
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_pulse
);

  localparam logic [NUM_LEDS-1:0] MSB_ONLY = {1'b1, {(NUM_LEDS-1){1'b0}}};

  mode_t               mode_q;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [NUM_LEDS-1:0] pattern_d;
  logic                bounce_down_q;
  logic                bounce_down_d;
  logic                step_pulse_q;
  logic                mode_chg;
  logic                tick;

  assign mode_chg = (mode_t'(mode) != mode_q);

  tick_divider #(
    .PRESCALE (PRESCALE),
    .CNT_W    ((PRE_W < 1) ? 1 : PRE_W)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (mode_chg),
    .tick   (tick)
  );

  // Next pattern if a step were taken this cycle.
  always_comb begin
    pattern_d     = pattern_q;
    bounce_down_d = bounce_down_q;
    case (mode_q)
      MODE_ROTATE: begin
        if (dir == DIR_LEFT) begin
          pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
        end else begin
          pattern_d = {pattern_q[0], pattern_q[NUM_LEDS-1:1]};
        end
      end
      MODE_BOUNCE: begin
        if (!bounce_down_q) begin
          if (pattern_q[NUM_LEDS-1]) begin
            bounce_down_d = 1'b1;
            pattern_d     = pattern_q >> 1;
          end else begin
            pattern_d = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            bounce_down_d = 1'b0;
            pattern_d     = pattern_q << 1;
          end else begin
            pattern_d = pattern_q >> 1;
          end
        end
      end
      MODE_COUNT: begin
        if (dir == DIR_LEFT) begin
          pattern_d = pattern_q + NUM_LEDS'(1);
        end else begin
          pattern_d = pattern_q - NUM_LEDS'(1);
        end
      end
      MODE_FILL: begin
        if (&pattern_q) begin
          pattern_d = '0;
        end else if (dir == DIR_LEFT) begin
          pattern_d = (pattern_q << 1) | NUM_LEDS'(1);
        end else begin
          pattern_d = (pattern_q >> 1) | MSB_ONLY;
        end
      end
      default: pattern_d = pattern_q;
    endcase
  end

  // A mode change outranks a coincident terminal count: the new mode restarts cleanly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q        <= MODE_ROTATE;
      pattern_q     <= NUM_LEDS'(1);
      bounce_down_q <= 1'b0;
      step_pulse_q  <= 1'b0;
    end else if (mode_chg) begin
      mode_q        <= mode_t'(mode);
      pattern_q     <= NUM_LEDS'(init_pattern(mode_t'(mode)));
      bounce_down_q <= 1'b0;
      step_pulse_q  <= 1'b0;
    end else if (tick) begin
      pattern_q     <= pattern_d;
      bounce_down_q <= bounce_down_d;
      step_pulse_q  <= 1'b1;
    end else begin
      step_pulse_q  <= 1'b0;
    end
  end

  assign step_pulse = step_pulse_q;

`ifdef LED_PATTERN_GEN_PWM_EN
  logic [7:0] pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  assign leds = pattern_q & {NUM_LEDS{pwm_cnt_q < duty}};
`else
  assign leds = pattern_q;
`endif

endmodule
